mac_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one MAC unit among four requesters. It accepts per-requester operand pairs and runs one go/done transaction on the MAC for the winning requester. It then returns the 12-bit MAC result and a one-cycle ack to that requester. It sits between the requesting blocks and the MAC top module, and owns that module's `go`, `A` and `B` inputs.

---
 rtl/mac_arbiter_if.sv | 31 +++
 rtl/mac_arbiter.sv | 109 ++++++++++
 tb/tb_mac_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_arbiter_if.sv
// Bundle of the requester-side and MAC-side signals of mac_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and models the MAC.
interface mac_arbiter_if;
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [11:0] result;
    logic        err;
    logic        busy;
    logic        mac_go;
    logic [3:0]  mac_a;
    logic [3:0]  mac_b;
    logic [11:0] mac_out;
    logic        mac_done;
    logic [1:0]  state;

    // Handshake: a requester raises req[i] and holds its operand slices until grant[i];
    // the arbiter then pulses mac_go once, waits for mac_done (or timeout), and answers
    // with a one-cycle ack[i] carrying result/err. state mirrors the arbiter FSM for debug.
    modport slave (
        input  req, a_in, b_in, mac_out, mac_done,
        output grant, ack, result, err, busy, mac_go, mac_a, mac_b, state
    );

    modport master (
        output req, a_in, b_in, mac_out, mac_done,
        input  grant, ack, result, err, busy, mac_go, mac_a, mac_b, state
    );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one MAC among four requesters: capture operands,
// run one go/done transaction (with timeout), return result and a one-cycle ack.
module mac_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    mac_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [1:0]  last, idx, pick, cand;
    logic [7:0]  cnt;
    logic [3:0]  grant_q, ack_q, mac_a_q, mac_b_q;
    logic [11:0] result_q;
    logic        err_q, busy_q, go_q;

    // Scan farthest-to-nearest from last so the nearest requester after last wins;
    // k = 4 wraps to last itself, which therefore has the lowest priority.
    always_comb begin
        pick = 2'd0;
        cand = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (bus.req[cand]) pick = cand;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|bus.req) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (bus.mac_done || cnt == TO_LAST) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 2'd3;
            idx      <= 2'd0;
            cnt      <= 8'd0;
            grant_q  <= 4'd0;
            ack_q    <= 4'd0;
            result_q <= 12'd0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            go_q     <= 1'b0;
            mac_a_q  <= 4'd0;
            mac_b_q  <= 4'd0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            go_q   <= (state == IDLE) && (state_next == START);
            ack_q  <= 4'd0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        idx     <= pick;
                        grant_q <= 4'b0001 << pick;
                        mac_a_q <= bus.a_in[{pick, 2'b00} +: 4];
                        mac_b_q <= bus.b_in[{pick, 2'b00} +: 4];
                        cnt     <= 8'd0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // Completion takes precedence over a timeout in the same cycle.
                    if (bus.mac_done) begin
                        result_q <= bus.mac_out;
                        err_q    <= 1'b0;
                        ack_q    <= 4'b0001 << idx;
                    end else if (cnt == TO_LAST) begin
                        result_q <= 12'd0;
                        err_q    <= 1'b1;
                        ack_q    <= 4'b0001 << idx;
                    end
                end
                RESP: begin
                    last    <= idx;
                    grant_q <= 4'd0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant  = grant_q;
    assign bus.ack    = ack_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.mac_go = go_q;
    assign bus.mac_a  = mac_a_q;
    assign bus.mac_b  = mac_b_q;
    assign bus.state  = state;
endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: MAC model with programmable latency, ack scoreboard,
// and one task per scenario.
module tb_mac_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    mac_arbiter_if bus ();

    mac_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc_n  = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Expected ack entries: {err, idx[1:0], result[11:0]}
    logic [14:0] exp_q[$];
    logic [14:0] mon_e;

    function automatic logic [14:0] mk(input logic e, input logic [1:0] i, input logic [11:0] r);
        return {e, i, r};
    endfunction

    // MAC model: done arrives in WAIT cycle 'lat' (0-based); never=1 suppresses it.
    int         lat   = 0;
    bit         never = 1'b0;
    int         timer = 0;
    logic [7:0] prod;
    always @(negedge clk) begin
        if (rst) begin
            timer        = 0;
            bus.mac_done = 1'b0;
            bus.mac_out  = 12'd0;
        end else if (bus.mac_go) begin
            prod         = {4'd0, bus.mac_a} * {4'd0, bus.mac_b};
            timer        = never ? 0 : lat + 1;
            bus.mac_done = 1'b0;
            bus.mac_out  = 12'($urandom);
        end else if (timer > 0) begin
            timer        = timer - 1;
            bus.mac_done = (timer == 0);
            bus.mac_out  = (timer == 0) ? {4'd0, prod} : 12'($urandom);
        end else begin
            bus.mac_done = 1'b0;
            bus.mac_out  = 12'($urandom);
        end
    end

    // Scoreboard: every ack is popped against the queue.
    always @(negedge clk) begin
        if (!rst && bus.ack !== 4'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_ack: ack=%b result=%0d err=%b, none expected", bus.ack, bus.result, bus.err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.ack, bus.grant, bus.result, bus.err} !==
                    {4'b0001 << mon_e[13:12], 4'b0001 << mon_e[13:12], mon_e[11:0], mon_e[14]})
                    $display("FAIL ack_scoreboard: ack=%b grant=%b result=%0d err=%b, required idx=%0d result=%0d err=%b",
                             bus.ack, bus.grant, bus.result, bus.err, mon_e[13:12], mon_e[11:0], mon_e[14]);
                else
                    passed++;
            end
        end
    end

    task automatic apply_reset();
        rst     = 1'b1;
        bus.req = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for n acks (bounded), drop req after the last one, then confirm the queue drained.
    task automatic run_acks(input int n, input int budget, input string name, output int max_grants);
        int seen = 0;
        int cyc  = 0;
        max_grants = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if ($countones(bus.grant) > max_grants) max_grants = $countones(bus.grant);
            if (bus.ack !== 4'd0) seen++;
        end
        bus.req = 4'd0;
        checks++;
        if (seen != n) $display("FAIL %s_ack_count: saw %0d acks, required %0d", name, seen, n);
        else passed++;
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: %0d entries left, required 0", name, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.grant, bus.ack, bus.result, bus.err, bus.busy, bus.mac_go, bus.mac_a, bus.mac_b, bus.state} !== 33'd0)
            $display("FAIL reset_outputs: grant=%b ack=%b result=%0d err=%b busy=%b go=%b a=%0d b=%0d state=%0d, required all 0",
                     bus.grant, bus.ack, bus.result, bus.err, bus.busy, bus.mac_go, bus.mac_a, bus.mac_b, bus.state);
        else passed++;
    endtask

    task automatic test_single();
        int gos = 0;
        int cyc = 0;
        bit got = 1'b0;
        apply_reset();
        never    = 1'b0;
        lat      = 2;
        bus.a_in = 16'h0003;
        bus.b_in = 16'h0005;
        exp_q.push_back(mk(1'b0, 2'd0, 12'd15));
        bus.req = 4'b0001;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.mac_go) begin
                gos++;
                checks++;
                if (bus.mac_a !== 4'd3 || bus.mac_b !== 4'd5)
                    $display("FAIL single_operands: mac_a=%0d mac_b=%0d, required 3 5", bus.mac_a, bus.mac_b);
                else passed++;
            end
            // Drop req and scramble operands after capture; neither may disturb the transaction.
            if (bus.grant !== 4'd0) begin
                bus.req  = 4'd0;
                bus.a_in = 16'hffff;
                bus.b_in = 16'hffff;
            end
            if (bus.ack !== 4'd0) begin
                got = 1'b1;
                checks++;
                if (bus.mac_a !== 4'd3 || bus.mac_b !== 4'd5 || bus.busy !== 1'b1)
                    $display("FAIL single_hold: mac_a=%0d mac_b=%0d busy=%b in ack cycle, required 3 5 1", bus.mac_a, bus.mac_b, bus.busy);
                else passed++;
            end
        end
        checks++;
        if (gos != 1 || !got) $display("FAIL single_go: go pulses=%0d ack_seen=%b, required 1 1", gos, got);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.state !== 2'd0 || bus.err !== 1'b0 || bus.result !== 12'd15)
            $display("FAIL single_after: busy=%b state=%0d err=%b result=%0d, required 0 0 0 15", bus.busy, bus.state, bus.err, bus.result);
        else passed++;
    endtask

    task automatic test_simultaneous();
        int mg;
        apply_reset();
        lat      = $urandom_range(0, 3);
        bus.a_in = {4'd4, 4'd3, 4'd2, 4'd1};
        bus.b_in = 16'h2222;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 2'(i), 12'(2 * (i + 1))));
        bus.req = 4'b1111;
        run_acks(4, 120, "simul", mg);
        checks++;
        if (mg != 1) $display("FAIL simul_onehot: max grant bits=%0d, required 1", mg);
        else passed++;
    endtask

    task automatic test_fairness();
        int mg;
        apply_reset();
        lat      = 1;
        bus.a_in = {4'd0, 4'd7, 4'd0, 4'd5};
        bus.b_in = 16'h0302;
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? mk(1'b0, 2'd0, 12'd10) : mk(1'b0, 2'd2, 12'd21));
        bus.req = 4'b0101;
        run_acks(6, 150, "fair", mg);
    endtask

    task automatic test_timeout();
        int g   = -1;
        int k   = -1;
        int cyc = 0;
        int mg;
        apply_reset();
        never    = 1'b1;
        bus.a_in = 16'h00a0;
        bus.b_in = 16'h00b0;
        exp_q.push_back(mk(1'b1, 2'd1, 12'd0));
        bus.req = 4'b0010;
        while (k < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.mac_go) begin
                g       = cyc_n;
                bus.req = 4'd0;
            end
            if (bus.ack !== 4'd0) k = cyc_n;
        end
        checks++;
        if (g < 0 || k < 0 || (k - g + 1) != TO + 2)
            $display("FAIL timeout_latency: go..ack spans %0d cycles inclusive, required %0d", k - g + 1, TO + 2);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) $display("FAIL timeout_err_pulse: err=%b after ack cycle, required 0", bus.err);
        else passed++;
        never    = 1'b0;
        lat      = 1;
        bus.a_in = 16'h0900;
        bus.b_in = 16'h0300;
        exp_q.push_back(mk(1'b0, 2'd2, 12'd27));
        bus.req = 4'b0100;
        run_acks(1, 40, "post_timeout", mg);
    endtask

    task automatic test_collision();
        int mg;
        apply_reset();
        never    = 1'b0;
        lat      = TO - 1;
        bus.a_in = 16'h0006;
        bus.b_in = 16'h0007;
        exp_q.push_back(mk(1'b0, 2'd0, 12'd42));
        bus.req = 4'b0001;
        run_acks(1, 40, "collide", mg);
        // One cycle too late: timeout fires, and the late done lands in RESP and is ignored.
        lat      = TO;
        bus.a_in = 16'h5000;
        bus.b_in = 16'h5000;
        exp_q.push_back(mk(1'b1, 2'd3, 12'd0));
        bus.req = 4'b1000;
        run_acks(1, 40, "late_done", mg);
    endtask

    task automatic test_reset_mid_wait();
        int mg;
        int cyc = 0;
        apply_reset();
        never    = 1'b0;
        lat      = 1;
        bus.a_in = 16'h0020;
        bus.b_in = 16'h0040;
        exp_q.push_back(mk(1'b0, 2'd1, 12'd8));
        bus.req = 4'b0010;
        run_acks(1, 40, "pre_rst", mg);
        never   = 1'b1;
        bus.req = 4'b0100;
        while (!bus.mac_go && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        bus.req = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state !== 2'd2) $display("FAIL rst_mid_in_wait: state=%0d, required 2", bus.state);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.grant, bus.ack, bus.result, bus.err, bus.busy, bus.mac_go, bus.mac_a, bus.mac_b, bus.state} !== 33'd0)
            $display("FAIL rst_mid_outputs: grant=%b ack=%b result=%0d err=%b busy=%b go=%b a=%0d b=%0d state=%0d, required all 0",
                     bus.grant, bus.ack, bus.result, bus.err, bus.busy, bus.mac_go, bus.mac_a, bus.mac_b, bus.state);
        else passed++;
        repeat (TO + 4) @(negedge clk);
        never    = 1'b0;
        lat      = 0;
        bus.a_in = 16'h9002;
        bus.b_in = 16'h1003;
        exp_q.push_back(mk(1'b0, 2'd0, 12'd6));
        bus.req = 4'b1001;
        run_acks(1, 40, "post_rst", mg);
    endtask

    initial begin
        rst          = 1'b1;
        bus.req      = 4'd0;
        bus.a_in     = 16'd0;
        bus.b_in     = 16'd0;
        bus.mac_done = 1'b0;
        bus.mac_out  = 12'd0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_collision();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
